// File: rtl/ofdm_payload_demap.sv
// ofdm_payload_demap: hard-decision BPSK/QPSK/16-QAM/64-QAM demapper packing bits LSB-first into bytes
module ofdm_payload_demap #(
  parameter int DATA_SIZE = 16,
  parameter int IQ_WIDTH  = 16,
  parameter int AMP       = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [IQ_WIDTH-1:0] in_data_i,
  input  logic signed [IQ_WIDTH-1:0] in_data_q,
  input  logic [2:0]                 modulation,
  output logic                       flag_ready_recive,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       symbol_done,
  output logic [15:0]                counter_data,
  output logic                       mod_error
);
  localparam int CW = $clog2(DATA_SIZE);
  localparam logic [IQ_WIDTH-1:0] T2   = IQ_WIDTH'(2 * AMP);
  localparam logic [IQ_WIDTH-1:0] T4   = IQ_WIDTH'(4 * AMP);
  localparam logic [IQ_WIDTH-1:0] T6   = IQ_WIDTH'(6 * AMP);
  localparam logic [IQ_WIDTH-1:0] MAXV = {1'b0, {(IQ_WIDTH-1){1'b1}}};
  typedef enum logic {IDLE, RECV} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0] mod_lat, mod_eff;
  logic [13:0] acc, acc_sum;
  logic [3:0] acc_n, n_sum, nb, di, dq;
  logic [5:0] sb;
  logic ok, accept, last, fire;
  // returns {m2, m1 (64-QAM), m1 (16-QAM), sign}; most negative input saturates
  function automatic logic [3:0] decide(input logic [IQ_WIDTH-1:0] x);
    logic [IQ_WIDTH-1:0] a;
    a = !x[IQ_WIDTH-1] ? x : (x == ~MAXV) ? MAXV : -x;
    return {a > T2 && a < T6, a > T4, a > T2, x[IQ_WIDTH-1]};
  endfunction
  always_comb begin
    flag_ready_recive = !out_valid || out_ready;
    accept = in_valid && flag_ready_recive;
    last = cnt == CW'(DATA_SIZE - 1);
    mod_eff = state == IDLE ? modulation : mod_lat;
    di = decide(in_data_i);
    dq = decide(in_data_q);
    sb = '0;
    nb = '0;
    ok = 1'b1;
    case (mod_eff)
      3'd1: begin sb = {5'b0, di[0]}; nb = 4'd1; end
      3'd2: begin sb = {4'b0, dq[0], di[0]}; nb = 4'd2; end
      3'd4: begin sb = {2'b0, dq[1], dq[0], di[1], di[0]}; nb = 4'd4; end
      3'd6: begin sb = {dq[3], dq[2], dq[0], di[3], di[2], di[0]}; nb = 4'd6; end
      default: ok = 1'b0;
    endcase
    acc_sum = acc | (14'(sb) << acc_n);
    n_sum = acc_n + nb;
    fire = accept && ok && n_sum >= 4'd8;
    state_nx = accept ? (last ? IDLE : RECV) : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      mod_lat <= '0;
      acc <= '0;
      acc_n <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      symbol_done <= 1'b0;
      counter_data <= '0;
      mod_error <= 1'b0;
    end else begin
      symbol_done <= accept && last;
      if (out_valid && out_ready) counter_data <= counter_data + 16'd1;
      out_valid <= fire || (out_valid && !out_ready);
      if (fire) out_data <= acc_sum[7:0];
      if (accept) begin
        cnt <= last ? '0 : cnt + CW'(1);
        if (state == IDLE) mod_lat <= modulation;
        if (!ok) mod_error <= 1'b1;
        acc <= !ok ? '0 : fire ? acc_sum >> 8 : acc_sum;
        acc_n <= !ok ? '0 : fire ? n_sum - 4'd8 : n_sum;
      end
    end
  end
endmodule

// File: tb/tb_ofdm_payload_demap.sv
// tb_ofdm_payload_demap: directed vector table plus hand-written backpressure/error/reset sequences
module tb_ofdm_payload_demap;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic signed [15:0] in_data_i = '0, in_data_q = '0;
  logic [2:0] modulation = 3'd1;
  logic flag_ready_recive, out_valid, symbol_done, mod_error;
  logic [7:0] out_data;
  logic [15:0] counter_data;
  int checks = 0, errors = 0, symcnt = 0;
  logic [7:0] got[$];

  ofdm_payload_demap dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data_i(in_data_i),
    .in_data_q(in_data_q), .modulation(modulation), .flag_ready_recive(flag_ready_recive),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .symbol_done(symbol_done), .counter_data(counter_data), .mod_error(mod_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && out_valid && out_ready) got.push_back(out_data);
    if (reset && symbol_done) symcnt++;
  end

  typedef struct {
    logic [2:0]         md;
    logic signed [15:0] i0, i1, q;
    int                 n, nb;
    logic [31:0]        exp;
  } vec_t;
  vec_t v[8];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // sample k uses i0 for even k, i1 for odd k; waits (bounded) for acceptance
  task automatic feed(input int n, input logic signed [15:0] i0, input logic signed [15:0] i1,
                      input logic signed [15:0] q);
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data_i = (k % 2 == 0) ? i0 : i1;
      in_data_q = q;
      while (!flag_ready_recive && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) chk("feed_timeout", 0, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int qb, sb0;
    v[0] = '{3'd1, -16'sd4096, 16'sd4096, 16'sd0, 16, 2, 32'h00005555};
    v[1] = '{3'd2, -16'sd4096, -16'sd4096, 16'sd4096, 16, 4, 32'h55555555};
    v[2] = '{3'd4, 16'sd12288, 16'sd12288, -16'sd4096, 2, 1, 32'h00000066};
    v[3] = '{3'd4, 16'sd8192, 16'sd8192, 16'sd8193, 2, 1, 32'h00000088};
    v[4] = '{3'd6, 16'sd20480, 16'sd20480, -16'sd28672, 4, 3, 32'h0079E79E};
    v[5] = '{3'd6, -16'sd32768, -16'sd32768, 16'sd0, 4, 3, 32'h000C30C3};
    v[6] = '{3'd6, 16'sd16384, 16'sd16384, 16'sd24576, 4, 3, 32'h00514514};
    v[7] = '{3'd2, 16'sd0, 16'sd0, -16'sd1, 4, 1, 32'h000000AA};

    repeat (3) @(negedge clk);
    chk("rst_ready", flag_ready_recive, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_done", symbol_done, 0);
    chk("rst_count", counter_data, 0);
    chk("rst_moderr", mod_error, 0);
    reset = 1'b1;

    for (int t = 0; t < 8; t++) begin
      do_reset();
      qb = got.size();
      sb0 = symcnt;
      modulation = v[t].md;
      out_ready = 1'b1;
      feed(v[t].n, v[t].i0, v[t].i1, v[t].q);
      chk($sformatf("v%0d_done_pulse", t), symbol_done, v[t].n == 16 ? 1 : 0);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_nbytes", t), got.size() - qb, v[t].nb);
      for (int k = 0; k < v[t].nb && k < 4; k++)
        if (qb + k < got.size()) chk($sformatf("v%0d_byte%0d", t, k), got[qb+k], v[t].exp[8*k+:8]);
      chk($sformatf("v%0d_counter", t), counter_data, v[t].nb);
      chk($sformatf("v%0d_symcnt", t), symcnt - sb0, v[t].n == 16 ? 1 : 0);
      chk($sformatf("v%0d_moderr", t), mod_error, 0);
    end

    // modulation changes mid-symbol are ignored
    do_reset();
    qb = got.size();
    modulation = 3'd2;
    feed(1, -16'sd4096, -16'sd4096, 16'sd4096);
    modulation = 3'd1;
    feed(3, -16'sd4096, -16'sd4096, 16'sd4096);
    repeat (2) @(negedge clk);
    chk("latch_nbytes", got.size() - qb, 1);
    if (got.size() > qb) chk("latch_byte", got[qb], 8'h55);

    // backpressure: stall 5 cycles with a sample pending
    do_reset();
    qb = got.size();
    sb0 = symcnt;
    modulation = 3'd2;
    out_ready = 1'b0;
    feed(4, -16'sd4096, -16'sd4096, 16'sd4096);
    chk("bp_valid", out_valid, 1);
    chk("bp_ready_low", flag_ready_recive, 0);
    in_valid = 1'b1;
    in_data_i = 16'sd4096;
    in_data_q = -16'sd4096;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_data%0d", c), out_data, 8'h55);
      chk($sformatf("bp_hold_ready%0d", c), flag_ready_recive, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    feed(12, 16'sd4096, 16'sd4096, -16'sd4096);
    chk("bp_done_pulse", symbol_done, 1);
    repeat (3) @(negedge clk);
    chk("bp_nbytes", got.size() - qb, 4);
    for (int k = 0; k < 4; k++)
      if (qb + k < got.size()) chk($sformatf("bp_byte%0d", k), got[qb+k], k == 0 ? 8'h55 : 8'hAA);
    chk("bp_counter", counter_data, 4);
    chk("bp_symcnt", symcnt - sb0, 1);

    // unsupported modulation, then a clean symbol, then reset mid-symbol
    do_reset();
    qb = got.size();
    sb0 = symcnt;
    modulation = 3'd3;
    feed(16, -16'sd4096, -16'sd4096, 16'sd4096);
    chk("bad_done_pulse", symbol_done, 1);
    repeat (3) @(negedge clk);
    chk("bad_nbytes", got.size() - qb, 0);
    chk("bad_valid", out_valid, 0);
    chk("bad_moderr", mod_error, 1);
    chk("bad_symcnt", symcnt - sb0, 1);
    chk("bad_counter", counter_data, 0);
    modulation = 3'd2;
    feed(16, -16'sd4096, -16'sd4096, 16'sd4096);
    repeat (3) @(negedge clk);
    chk("after_bad_nbytes", got.size() - qb, 4);
    if (got.size() > qb) chk("after_bad_byte", got[qb], 8'h55);
    chk("after_bad_moderr", mod_error, 1);
    chk("after_bad_counter", counter_data, 4);
    out_ready = 1'b0;
    feed(4, -16'sd4096, -16'sd4096, 16'sd4096);
    chk("mid_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_ready", flag_ready_recive, 1);
    chk("mid_rst_count", counter_data, 0);
    chk("mid_rst_done", symbol_done, 0);
    chk("mid_rst_moderr", mod_error, 0);
    @(negedge clk);
    reset = 1'b1;
    qb = got.size();
    out_ready = 1'b1;
    feed(16, -16'sd4096, -16'sd4096, 16'sd4096);
    chk("post_rst_done_pulse", symbol_done, 1);
    repeat (3) @(negedge clk);
    chk("post_rst_nbytes", got.size() - qb, 4);
    chk("post_rst_counter", counter_data, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
